// File: rtl/cpu_bus_serializer.sv
// cpu_bus_serializer
//   Narrows one CPU bus transaction (address, write data, read data) onto a
//   PIN_W-wide pin interface. Sequence per transaction:
//   ADDR (NA beats), CMD (1 cycle), DATA (ND beats, gated by ext_ready), DONE.
//   Write transactions drive dq in DATA; reads capture dq instead.
//   Every beat goes out least-significant slice first.
//
//   Optional build macro: WAIT_TIMEOUT_EN
//     Defined   : TIMEOUT consecutive ext_ready=0 cycles in DATA abort the
//                 transaction (cpu_err=1). For an aborted read, slices that
//                 were never received read back as all-ones.
//     Undefined : DATA waits indefinitely and cpu_err is constant 0.
//
// Ports
//   clk, rst            clock and synchronous active-high reset
//   cpu_req/we/addr/wdata  transaction request, latched on accept in IDLE
//   cpu_busy            state is not IDLE
//   cpu_ack, cpu_err    one-cycle completion pulse and its abort flag
//   cpu_rdata           last completed read result
//   pin_addr            address beat (ADDR) or command beat (CMD)
//   pin_dq_out/oe       write-data beat and dq drive enable
//   pin_dq_in           read-data beat
//   pin_phase           00 idle, 01 addr, 10 cmd, 11 data
//   ext_ready           external device ready; gates data beats
module cpu_bus_serializer #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int PIN_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_busy,
    output logic              cpu_ack,
    output logic              cpu_err,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [PIN_W-1:0]  pin_addr,
    output logic [PIN_W-1:0]  pin_dq_out,
    output logic              pin_dq_oe,
    input  logic [PIN_W-1:0]  pin_dq_in,
    output logic [1:0]        pin_phase,
    input  logic              ext_ready
);

    // state  | meaning
    // S_IDLE | waiting for cpu_req; pins quiet
    // S_ADDR | NA address beats, one per cycle
    // S_CMD  | single command beat {1, we}; dq never driven here
    // S_DATA | ND data beats, each completes on ext_ready=1
    // S_DONE | cpu_ack pulse; requests ignored; pins quiet
    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_CMD,
        S_DATA,
        S_DONE
    } state_t;

    localparam int NA   = ADDR_W / PIN_W;
    localparam int ND   = DATA_W / PIN_W;
    localparam int NMAX = (NA > ND) ? NA : ND;
    localparam int BW   = (NMAX > 1) ? $clog2(NMAX) : 1;
    localparam logic [BW-1:0] NA_LAST = BW'(NA - 1);
    localparam logic [BW-1:0] ND_LAST = BW'(ND - 1);

    if ((ADDR_W % PIN_W) != 0 || (DATA_W % PIN_W) != 0 || PIN_W < 2 || TIMEOUT < 1)
    begin : g_param_check
        $error("cpu_bus_serializer: widths must be multiples of PIN_W, PIN_W >= 2, TIMEOUT >= 1");
    end

    state_t            state, state_nxt;
    logic [BW-1:0]     beat, beat_nxt;
    logic              we_q, we_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic [DATA_W-1:0] wdata_q, wdata_nxt;
    logic [DATA_W-1:0] rshift, rshift_nxt;
    logic              abort;
    logic              rdata_load;

    logic [1:0]        phase_nxt;
    logic [PIN_W-1:0]  pin_addr_nxt;
    logic [PIN_W-1:0]  dq_out_nxt;
    logic              oe_nxt;
    logic              ack_nxt;
    logic              err_nxt;

`ifdef WAIT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    // Down-counter of remaining tolerated stall cycles; reloads outside DATA
    // and on every ready cycle, so only consecutive stalls count.
    logic [TW-1:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state != S_DATA || ext_ready) begin
            wait_cnt <= TW'(TIMEOUT);
        end else begin
            wait_cnt <= wait_cnt - 1'b1;
        end
    end
`endif

    always_comb begin
        state_nxt  = state;
        beat_nxt   = beat;
        we_nxt     = we_q;
        addr_nxt   = addr_q;
        wdata_nxt  = wdata_q;
        rshift_nxt = rshift;
        abort      = 1'b0;
        case (state)
            S_IDLE: begin
                if (cpu_req) begin
                    state_nxt  = S_ADDR;
                    beat_nxt   = '0;
                    we_nxt     = cpu_we;
                    addr_nxt   = cpu_addr;
                    wdata_nxt  = cpu_wdata;
                    // Preset to all-ones so slices never received on an abort
                    // read back as ones.
                    rshift_nxt = '1;
                end
            end
            S_ADDR: begin
                if (beat == NA_LAST) begin
                    state_nxt = S_CMD;
                    beat_nxt  = '0;
                end else begin
                    beat_nxt = beat + 1'b1;
                end
            end
            S_CMD: begin
                state_nxt = S_DATA;
                beat_nxt  = '0;
            end
            S_DATA: begin
                if (ext_ready) begin
                    if (!we_q) begin
                        rshift_nxt[int'(beat)*PIN_W +: PIN_W] = pin_dq_in;
                    end
                    if (beat == ND_LAST) begin
                        state_nxt = S_DONE;
                        beat_nxt  = '0;
                    end else begin
                        beat_nxt = beat + 1'b1;
                    end
                end
`ifdef WAIT_TIMEOUT_EN
                else if (wait_cnt == TW'(1)) begin
                    state_nxt = S_DONE;
                    beat_nxt  = '0;
                    abort     = 1'b1;
                end
`endif
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign rdata_load = (state == S_DATA) && (state_nxt == S_DONE) && !we_q;

    // Pin outputs are decoded from the next state so they are registered yet
    // aligned with the state they describe.
    always_comb begin
        phase_nxt    = 2'b00;
        pin_addr_nxt = '0;
        dq_out_nxt   = '0;
        oe_nxt       = 1'b0;
        ack_nxt      = 1'b0;
        err_nxt      = 1'b0;
        case (state_nxt)
            S_ADDR: begin
                phase_nxt    = 2'b01;
                pin_addr_nxt = addr_nxt[int'(beat_nxt)*PIN_W +: PIN_W];
            end
            S_CMD: begin
                phase_nxt    = 2'b10;
                pin_addr_nxt = PIN_W'({1'b1, we_nxt});
            end
            S_DATA: begin
                phase_nxt = 2'b11;
                oe_nxt    = we_nxt;
                if (we_nxt) begin
                    dq_out_nxt = wdata_nxt[int'(beat_nxt)*PIN_W +: PIN_W];
                end
            end
            S_DONE: begin
                ack_nxt = 1'b1;
                err_nxt = abort;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            beat       <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rshift     <= '0;
            cpu_rdata  <= '0;
            cpu_ack    <= 1'b0;
            cpu_err    <= 1'b0;
            pin_addr   <= '0;
            pin_dq_out <= '0;
            pin_dq_oe  <= 1'b0;
            pin_phase  <= 2'b00;
        end else begin
            state      <= state_nxt;
            beat       <= beat_nxt;
            we_q       <= we_nxt;
            addr_q     <= addr_nxt;
            wdata_q    <= wdata_nxt;
            rshift     <= rshift_nxt;
            cpu_ack    <= ack_nxt;
            cpu_err    <= err_nxt;
            pin_addr   <= pin_addr_nxt;
            pin_dq_out <= dq_out_nxt;
            pin_dq_oe  <= oe_nxt;
            pin_phase  <= phase_nxt;
            if (rdata_load) begin
                cpu_rdata <= rshift_nxt;
            end
        end
    end

    assign cpu_busy = (state != S_IDLE);

endmodule

// File: tb/tb_cpu_bus_serializer.sv
// tb_cpu_bus_serializer
//   Directed bench for cpu_bus_serializer at default widths. A transaction-
//   level model tracks where each transaction should be and what the pins
//   should show; a compare process checks every output against it on each
//   falling edge. Directed tests add literal expectations for sequences,
//   latency and read data. Define WAIT_TIMEOUT_EN to also run the abort test
//   (TIMEOUT=4).
module tb_cpu_bus_serializer;

    localparam int NA = 8;
    localparam int ND = 8;
`ifdef WAIT_TIMEOUT_EN
    localparam int TB_TIMEOUT = 4;
`else
    localparam int TB_TIMEOUT = 255;
`endif

    logic        clk;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [63:0] cpu_addr;
    logic [63:0] cpu_wdata;
    logic        cpu_busy;
    logic        cpu_ack;
    logic        cpu_err;
    logic [63:0] cpu_rdata;
    logic [7:0]  pin_addr;
    logic [7:0]  pin_dq_out;
    logic        pin_dq_oe;
    logic [7:0]  pin_dq_in;
    logic [1:0]  pin_phase;
    logic        ext_ready;

    cpu_bus_serializer #(
        .ADDR_W (64),
        .DATA_W (64),
        .PIN_W  (8),
        .TIMEOUT(TB_TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_busy  (cpu_busy),
        .cpu_ack   (cpu_ack),
        .cpu_err   (cpu_err),
        .cpu_rdata (cpu_rdata),
        .pin_addr  (pin_addr),
        .pin_dq_out(pin_dq_out),
        .pin_dq_oe (pin_dq_oe),
        .pin_dq_in (pin_dq_in),
        .pin_phase (pin_phase),
        .ext_ready (ext_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Transaction-level model. m_ph: 0 idle, 1 address, 2 command, 3 data, 4 done.
    int          m_ph = 0;
    int          m_beat = 0;
    logic        m_we = 1'b0;
    logic [63:0] m_addr = '0;
    logic [63:0] m_wdata = '0;
    logic [63:0] m_rbuf = '0;
    logic [63:0] m_rdata = '0;
    logic        m_err = 1'b0;
`ifdef WAIT_TIMEOUT_EN
    int          m_wait = 0;
`endif

    always @(posedge clk) begin
        if (rst) begin
            m_ph = 0; m_beat = 0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
            m_rbuf = '0; m_rdata = '0; m_err = 1'b0;
        end else begin
            case (m_ph)
                0: if (cpu_req) begin
                    m_we = cpu_we; m_addr = cpu_addr; m_wdata = cpu_wdata;
                    m_rbuf = '1; m_beat = 0; m_ph = 1;
                end
                1: if (m_beat == NA - 1) begin m_ph = 2; m_beat = 0; end
                   else m_beat++;
                2: begin
                    m_ph = 3; m_beat = 0;
`ifdef WAIT_TIMEOUT_EN
                    m_wait = 0;
`endif
                end
                3: if (ext_ready) begin
                    if (!m_we) m_rbuf[m_beat*8 +: 8] = pin_dq_in;
`ifdef WAIT_TIMEOUT_EN
                    m_wait = 0;
`endif
                    if (m_beat == ND - 1) begin
                        m_ph = 4; m_err = 1'b0;
                        if (!m_we) m_rdata = m_rbuf;
                    end else m_beat++;
                end else begin
`ifdef WAIT_TIMEOUT_EN
                    m_wait++;
                    if (m_wait == TB_TIMEOUT) begin
                        m_ph = 4; m_err = 1'b1;
                        if (!m_we) m_rdata = m_rbuf;
                    end
`endif
                end
                default: m_ph = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", cpu_busy, m_ph != 0);
            check("ack", cpu_ack, m_ph == 4);
            check("err", cpu_err, (m_ph == 4) ? m_err : 1'b0);
            check("phase", pin_phase, (m_ph >= 1 && m_ph <= 3) ? m_ph : 0);
            check("pin_addr", pin_addr,
                  (m_ph == 1) ? m_addr[m_beat*8 +: 8] :
                  (m_ph == 2) ? {6'b0, 1'b1, m_we} : 8'h00);
            check("dq_oe", pin_dq_oe, (m_ph == 3) && m_we);
            check("dq_out", pin_dq_out, (m_ph == 3 && m_we) ? m_wdata[m_beat*8 +: 8] : 8'h00);
            check("rdata", cpu_rdata, m_rdata);
        end
    end

    // Results of the most recent run_txn.
    logic [7:0]  rbytes [8];
    logic [7:0]  r_aseq [8];
    logic [7:0]  r_dseq [8];
    logic [7:0]  r_cmd;
    int          r_lat;
    int          r_oe;
    int          r_dcyc;
    logic [63:0] r_rd;
    logic        r_err;

    // Issue one transaction from IDLE and follow it to cpu_ack. Latency counts
    // the accepting IDLE cycle as cycle 0. ext_ready drops for stall_len
    // cycles when data beat stall_beat is presented.
    task automatic run_txn(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                           input int stall_beat, input int stall_len);
        int na, dbeat, stall;
        logic done;
        @(negedge clk);
        cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
        na = 0; dbeat = 0; stall = stall_len; done = 1'b0;
        r_oe = 0; r_dcyc = 0; r_lat = -1; r_cmd = 8'h00; r_rd = '0; r_err = 1'b0;
        for (int i = 0; i < 8; i++) begin r_aseq[i] = 8'h00; r_dseq[i] = 8'h00; end
        for (int k = 1; k <= 200 && !done; k++) begin
            @(negedge clk);
            cpu_req = 1'b0;
            if (pin_phase == 2'b01 && na < 8) begin r_aseq[na] = pin_addr; na++; end
            if (pin_phase == 2'b10) r_cmd = pin_addr;
            if (pin_dq_oe) begin
                if (r_oe < 8) r_dseq[r_oe] = pin_dq_out;
                r_oe++;
            end
            if (pin_phase == 2'b11) begin
                r_dcyc++;
                pin_dq_in = (dbeat < 8) ? rbytes[dbeat] : 8'h00;
                if (dbeat == stall_beat && stall > 0) begin
                    ext_ready = 1'b0; stall--;
                end else begin
                    ext_ready = 1'b1; dbeat++;
                end
            end else begin
                ext_ready = 1'b1;
            end
            if (cpu_ack) begin done = 1'b1; r_lat = k; r_rd = cpu_rdata; r_err = cpu_err; end
        end
        check("txn_completed", done, 1'b1);
        ext_ready = 1'b1;
    endtask

    logic [7:0] exp_aseq [8];
    logic [7:0] exp_dseq [8];
    int   k_ack, nph;
    logic hit, got;

    initial begin
        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        pin_dq_in = 8'h00; ext_ready = 1'b1;
        rbytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("reset_busy", cpu_busy, 1'b0);
        check("reset_ack", cpu_ack, 1'b0);
        check("reset_phase", pin_phase, 2'b00);
        check("reset_rdata", cpu_rdata, 64'h0);
        rst = 1'b0;

        // Read, no stalls.
        run_txn(1'b0, 64'h0123456789ABCDEF, 64'h0, -1, 0);
        exp_aseq = '{8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
        for (int i = 0; i < 8; i++) check($sformatf("rd_addr_beat%0d", i), r_aseq[i], exp_aseq[i]);
        check("rd_cmd", r_cmd, 8'h02);
        check("rd_latency", r_lat, 18);
        check("rd_data", r_rd, 64'h8877665544332211);
        check("rd_err", r_err, 1'b0);
        check("rd_oe_cycles", r_oe, 0);

        // Write.
        run_txn(1'b1, 64'h0000_0000_0000_0040, 64'hDEADBEEFCAFEF00D, -1, 0);
        exp_dseq = '{8'h0D, 8'hF0, 8'hFE, 8'hCA, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        for (int i = 0; i < 8; i++) check($sformatf("wr_dq_beat%0d", i), r_dseq[i], exp_dseq[i]);
        check("wr_cmd", r_cmd, 8'h03);
        check("wr_oe_cycles", r_oe, 8);
        check("wr_latency", r_lat, 18);
        check("wr_rdata_kept", r_rd, 64'h8877665544332211);

        // Read with three wait cycles on data beat 2.
        rbytes = '{8'hA0, 8'hB1, 8'hC2, 8'hD3, 8'hE4, 8'hF5, 8'h06, 8'h17};
        run_txn(1'b0, 64'hFEDCBA9876543210, 64'h0, 2, 3);
        check("wait_latency", r_lat, 21);
        check("wait_data_cycles", r_dcyc, 11);
        check("wait_data", r_rd, 64'h1706F5E4D3C2B1A0);

        // cpu_req held high across a whole transaction.
        @(negedge clk);
        cpu_we = 1'b0; cpu_addr = 64'h1000; cpu_req = 1'b1; pin_dq_in = 8'h5A;
        k_ack = -1; hit = 1'b0;
        for (int k = 1; k <= 60 && !hit; k++) begin
            @(negedge clk);
            if (k_ack < 0) begin
                if (cpu_ack) k_ack = k;
            end else if (k == k_ack + 1) begin
                check("busyreq_idle_gap", cpu_busy, 1'b0);
            end else if (k == k_ack + 2) begin
                check("busyreq_restart", {cpu_busy, pin_phase}, 3'b101);
                cpu_req = 1'b0; hit = 1'b1;
            end
        end
        check("busyreq_reached", hit, 1'b1);
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (cpu_ack) got = 1'b1;
        end
        check("busyreq_second_ack", got, 1'b1);
        check("busyreq_second_data", cpu_rdata, 64'h5A5A5A5A5A5A5A5A);

        // Reset during address beat 4.
        @(negedge clk);
        cpu_we = 1'b0; cpu_addr = 64'hA5A5A5A5A5A5A5A5; cpu_req = 1'b1;
        nph = 0; hit = 1'b0;
        for (int k = 0; k < 20 && !hit; k++) begin
            @(negedge clk);
            cpu_req = 1'b0;
            if (pin_phase == 2'b01) begin
                if (nph == 4) begin rst = 1'b1; hit = 1'b1; end
                nph++;
            end
        end
        check("rstmid_reached", hit, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        check("rstmid_busy", cpu_busy, 1'b0);
        check("rstmid_phase", pin_phase, 2'b00);
        check("rstmid_pin_addr", pin_addr, 8'h00);
        check("rstmid_ack", cpu_ack, 1'b0);
        check("rstmid_rdata", cpu_rdata, 64'h0);
        rbytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        run_txn(1'b0, 64'h0123456789ABCDEF, 64'h0, -1, 0);
        check("rstmid_after_latency", r_lat, 18);
        check("rstmid_after_data", r_rd, 64'h8877665544332211);

`ifdef WAIT_TIMEOUT_EN
        // Stall from data beat 5 onward; abort after four stall cycles.
        rbytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        run_txn(1'b0, 64'h0123456789ABCDEF, 64'h0, 5, 1000);
        check("tmo_err", r_err, 1'b1);
        check("tmo_latency", r_lat, 19);
        check("tmo_data", r_rd, 64'hFFFFFF5544332211);
        run_txn(1'b0, 64'h0, 64'h0, -1, 0);
        check("tmo_recover_err", r_err, 1'b0);
        check("tmo_recover_data", r_rd, 64'h8877665544332211);
`endif

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
